intpol2_dn_ctrl: RTL and testbench
==================================

Name: intpol2_dn_ctrl

Overview:
Control path for the quadratic (2nd-order) interpolator, generalised to interpolation factor D=2^LOG2_D and NCH time-interleaved channels, with a FIFO bypass mode.
Sequences input-FIFO reads, sample-history loads, fractional-step (xi) generation and output-FIFO writes.
Stalls on input-empty and output-almost-full.
Sits between the input/output FIFOs and the intpol2 datapath; it replaces the fixed D=4, single-channel controller.

Parameters:
CONFIG_WIDTH, 32, width of ilen and the sample counter
LOG2_D, 2, log2 of interpolation factor D (1..8)
NCH, 1, number of interleaved channels (1..16)
CH_W, max(1,clog2(NCH)), channel index width (derived, localparam)

Ports:
clk  in  1  system clock
rstn  in  1  reset
start  in  1  begin a run (level, sampled in IDLE)
bypass  in  1  pass-through mode select, sampled with start
ilen  in  CONFIG_WIDTH  input samples per channel, latched at start
empty_i  in  1  input FIFO empty
afull_i  in  1  output FIFO almost full
rd_en  out  1  input FIFO read strobe (FWFT, data valid same cycle)
ld_m  out  1  shift sample history M0<-M1<-M2<-din for channel ch_sel
ch_sel  out  CH_W  channel currently addressed in the datapath
xi  out  LOG2_D  fractional step index for the current output
wr_en  out  1  output FIFO write strobe
fifo_bypass  out  1  datapath routes din straight to dout
clear  out  1  one-cycle datapath clear at run start
busy  out  1  high in every state except IDLE
stop_empty  out  1  read wanted but empty_i
stop_afull  out  1  write wanted but afull_i
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: asynchronous, active-low; clock clk, reset rstn. State IDLE; all counters 0; every output 0.
- States: IDLE, PRIME, FETCH, CALC, BYPASS, DONE. State and counters are registered. rd_en, wr_en, ld_m, stop_* are combinational from state and FIFO flags.
- IDLE, start=1:
  - latch ilen and bypass; pulse clear; ch=0, smp=0, xi=0.
  - bypass=1 and ilen=0 -> DONE.
  - bypass=1 otherwise -> BYPASS.
  - bypass=0 and ilen<3 -> DONE; no FIFO access.
  - otherwise -> PRIME.
- PRIME: needs 2*NCH reads. Each cycle with !empty_i: rd_en=ld_m=1, then ch advances. On wrap, the prime counter advances. After the second full pass: ch=0 -> FETCH.
- FETCH: wants one read. !empty_i -> rd_en=ld_m=1 for ch_sel, -> CALC with xi=0.
- CALC: wants D writes.
  - Each cycle with !afull_i: wr_en=1, xi++.
  - xi=D-1 write accepted, ch<NCH-1: ch++ -> FETCH.
  - xi=D-1 write accepted, ch=NCH-1: ch=0, smp++. If smp+1 = ilen-2 -> DONE, else -> FETCH.
- Output count per channel = (ilen-2)*D. Total reads = ilen*NCH.
- BYPASS: fifo_bypass=1. Each cycle with !empty_i && !afull_i: rd_en=wr_en=1 and (ch,smp) advances. After ilen*NCH transfers -> DONE. ch/smp counters avoid overflow of ilen*NCH.
- DONE: done=1 for one cycle, busy=0 -> IDLE. start is re-sampled only in IDLE.
- Stalls: state, xi and ch are held; strobes are 0 while stalled.
  - stop_empty=1 when state is PRIME, FETCH or BYPASS and empty_i.
  - stop_afull=1 when state is CALC, or BYPASS with !empty_i, and afull_i.
- Simultaneous empty_i and afull_i in BYPASS: stop_empty=1, stop_afull=0, no transfer.
- start while busy: ignored. Changes to ilen or bypass mid-run: ignored.
- Reset mid-run: immediate return to IDLE. No done pulse; FIFOs untouched.

Decomposition:
- Package intpol2_dn_pkg:
  - state encoding constants (3-bit);
  - localparams D and CH_W;
  - function clog2.
- Sub-module intpol2_dn_counters: xi, ch and smp counters with enables, sync clear, and terminal flags xi_last, ch_last, smp_last. The FSM consumes the flags.

Test Plan:
- LOG2_D=2, NCH=1, ilen=5, FIFOs never stall -> 5 reads; 12 writes with xi 0,1,2,3 repeating; one done pulse; busy deasserts the cycle after done.
- NCH=3, LOG2_D=1, ilen=4 -> PRIME reads ch 0,1,2,0,1,2. Then the ch_sel write pattern is 0,0,1,1,2,2 twice. 12 reads, 12 writes.
- Toggle empty_i during FETCH and afull_i during CALC at random -> stop_* track the flags exactly. No strobe while stalled. Write count is still 12 and the xi sequence is unbroken.
- bypass=1, NCH=2, ilen=3, with empty_i and afull_i both high for 2 cycles -> 6 transfers with rd_en==wr_en; fifo_bypass=1 throughout; stop_empty=1 and stop_afull=0 during the overlap.
- ilen=2 non-bypass and ilen=0 bypass -> done pulse two cycles after start; zero rd_en and zero wr_en.
- Assert rstn low during CALC -> next edge shows IDLE with all outputs 0 and no done pulse. A following start runs normally from PRIME.

Source files
------------

// File: rtl/intpol2_dn_pkg.sv
// rtl/intpol2_dn_pkg.sv - shared types, defaults and helpers for the intpol2 D/NCH controller
package intpol2_dn_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    localparam int LOG2_D_DEF = 2;
    localparam int NCH_DEF    = 1;
    localparam int D_DEF      = 1 << LOG2_D_DEF;
    localparam int CH_W_DEF   = (NCH_DEF > 1) ? clog2(NCH_DEF) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_FETCH  = 3'd2,
        S_CALC   = 3'd3,
        S_BYPASS = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/intpol2_dn_counters.sv
// rtl/intpol2_dn_counters.sv - xi / channel / sample counters with terminal flags
module intpol2_dn_counters #(
    parameter int CONFIG_WIDTH = 32,
    parameter int LOG2_D       = 2,
    parameter int NCH          = 1,
    parameter int CH_W         = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    xi_inc,
    input  logic                    ch_inc,
    input  logic                    smp_inc,
    input  logic                    smp_clr,
    input  logic [CONFIG_WIDTH-1:0] smp_lim,
    output logic [LOG2_D-1:0]       xi,
    output logic [CH_W-1:0]         ch,
    output logic                    xi_last,
    output logic                    ch_last,
    output logic                    smp_last
);
    localparam int D = 1 << LOG2_D;

    logic [LOG2_D-1:0]       xi_q, xi_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [CONFIG_WIDTH-1:0] smp_q, smp_d;

    assign xi       = xi_q;
    assign ch       = ch_q;
    assign xi_last  = (xi_q == LOG2_D'(D - 1));
    assign ch_last  = (ch_q == CH_W'(NCH - 1));
    assign smp_last = (smp_q == smp_lim);

    // xi is exactly LOG2_D wide, so it wraps to 0 on its own after D-1
    always_comb begin
        xi_d  = xi_q;
        ch_d  = ch_q;
        smp_d = smp_q;
        if (clr) begin
            xi_d  = '0;
            ch_d  = '0;
            smp_d = '0;
        end else begin
            if (xi_inc)
                xi_d = xi_q + LOG2_D'(1);
            if (ch_inc)
                ch_d = ch_last ? '0 : ch_q + CH_W'(1);
            if (smp_clr)
                smp_d = '0;
            else if (smp_inc)
                smp_d = smp_q + CONFIG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xi_q  <= '0;
            ch_q  <= '0;
            smp_q <= '0;
        end else begin
            xi_q  <= xi_d;
            ch_q  <= ch_d;
            smp_q <= smp_d;
        end
    end

endmodule

// File: rtl/intpol2_dn_ctrl.sv
// rtl/intpol2_dn_ctrl.sv - quadratic interpolator control FSM (D=2^LOG2_D, NCH channels, bypass)
module intpol2_dn_ctrl
    import intpol2_dn_pkg::*;
#(
    parameter int CONFIG_WIDTH = 32,
    parameter int LOG2_D       = LOG2_D_DEF,
    parameter int NCH          = NCH_DEF,
    localparam int CH_W        = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    bypass,
    input  logic [CONFIG_WIDTH-1:0] ilen,
    input  logic                    empty_i,
    input  logic                    afull_i,
    output logic                    rd_en,
    output logic                    ld_m,
    output logic [CH_W-1:0]         ch_sel,
    output logic [LOG2_D-1:0]       xi,
    output logic                    wr_en,
    output logic                    fifo_bypass,
    output logic                    clear,
    output logic                    busy,
    output logic                    stop_empty,
    output logic                    stop_afull,
    output logic                    done
);
    state_t                  state_q, state_d;
    logic [CONFIG_WIDTH-1:0] ilen_q, ilen_d;
    logic                    clear_q, clear_d;

    logic                    cnt_clr, xi_inc, ch_inc, smp_inc, smp_clr;
    logic [CONFIG_WIDTH-1:0] smp_lim;
    logic                    xi_last, ch_last, smp_last;

    intpol2_dn_counters #(
        .CONFIG_WIDTH(CONFIG_WIDTH),
        .LOG2_D      (LOG2_D),
        .NCH         (NCH),
        .CH_W        (CH_W)
    ) u_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (cnt_clr),
        .xi_inc  (xi_inc),
        .ch_inc  (ch_inc),
        .smp_inc (smp_inc),
        .smp_clr (smp_clr),
        .smp_lim (smp_lim),
        .xi      (xi),
        .ch      (ch_sel),
        .xi_last (xi_last),
        .ch_last (ch_last),
        .smp_last(smp_last)
    );

    // smp doubles as the prime-pass counter; smp_lim picks its terminal value per state
    always_comb begin
        state_d = state_q;
        ilen_d  = ilen_q;
        clear_d = 1'b0;
        cnt_clr = 1'b0;
        xi_inc  = 1'b0;
        ch_inc  = 1'b0;
        smp_inc = 1'b0;
        smp_clr = 1'b0;
        smp_lim = '0;
        rd_en   = 1'b0;
        ld_m    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ilen_d  = ilen;
                    clear_d = 1'b1;
                    cnt_clr = 1'b1;
                    if (bypass)
                        state_d = (ilen == '0) ? S_DONE : S_BYPASS;
                    else
                        state_d = (ilen < CONFIG_WIDTH'(3)) ? S_DONE : S_PRIME;
                end
            end
            S_PRIME: begin
                smp_lim = CONFIG_WIDTH'(1);
                if (!empty_i) begin
                    rd_en  = 1'b1;
                    ld_m   = 1'b1;
                    ch_inc = 1'b1;
                    if (ch_last) begin
                        if (smp_last) begin
                            smp_clr = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            smp_inc = 1'b1;
                        end
                    end
                end
            end
            S_FETCH: begin
                if (!empty_i) begin
                    rd_en   = 1'b1;
                    ld_m    = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                smp_lim = ilen_q - CONFIG_WIDTH'(3);
                if (!afull_i) begin
                    wr_en  = 1'b1;
                    xi_inc = 1'b1;
                    if (xi_last) begin
                        ch_inc  = 1'b1;
                        state_d = S_FETCH;
                        if (ch_last) begin
                            if (smp_last)
                                state_d = S_DONE;
                            else
                                smp_inc = 1'b1;
                        end
                    end
                end
            end
            S_BYPASS: begin
                smp_lim = ilen_q - CONFIG_WIDTH'(1);
                if (!empty_i && !afull_i) begin
                    rd_en  = 1'b1;
                    wr_en  = 1'b1;
                    ch_inc = 1'b1;
                    if (ch_last) begin
                        if (smp_last)
                            state_d = S_DONE;
                        else
                            smp_inc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                cnt_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ilen_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ilen_q  <= ilen_d;
            clear_q <= clear_d;
        end
    end

    assign clear       = clear_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign fifo_bypass = (state_q == S_BYPASS);
    assign stop_empty  = empty_i && ((state_q == S_PRIME) || (state_q == S_FETCH) ||
                                     (state_q == S_BYPASS));
    assign stop_afull  = afull_i && ((state_q == S_CALC) ||
                                     ((state_q == S_BYPASS) && !empty_i));

endmodule

// File: tb/tb_intpol2_dn_ctrl.sv
// tb/tb_intpol2_dn_ctrl.sv - self-checking bench for intpol2_dn_ctrl over three D/NCH configurations
module tb_intpol2_dn_ctrl;
    localparam int CW = 32;

    logic          clk;
    logic          rstn;
    logic [2:0]    st;
    logic          bypass;
    logic [CW-1:0] ilen;
    logic          empty_i, afull_i;
    logic [2:0]    rd, ld, wr, fb, cl, bz, se, sa, dn;
    logic [0:0]    ch_a;
    logic [1:0]    xi_a;
    logic [1:0]    ch_b;
    logic [0:0]    xi_b;
    logic [0:0]    ch_c;
    logic [0:0]    xi_c;

    intpol2_dn_ctrl #(.CONFIG_WIDTH(CW), .LOG2_D(2), .NCH(1)) u_a (
        .clk(clk), .rstn(rstn), .start(st[0]), .bypass(bypass), .ilen(ilen),
        .empty_i(empty_i), .afull_i(afull_i), .rd_en(rd[0]), .ld_m(ld[0]),
        .ch_sel(ch_a), .xi(xi_a), .wr_en(wr[0]), .fifo_bypass(fb[0]), .clear(cl[0]),
        .busy(bz[0]), .stop_empty(se[0]), .stop_afull(sa[0]), .done(dn[0]));

    intpol2_dn_ctrl #(.CONFIG_WIDTH(CW), .LOG2_D(1), .NCH(3)) u_b (
        .clk(clk), .rstn(rstn), .start(st[1]), .bypass(bypass), .ilen(ilen),
        .empty_i(empty_i), .afull_i(afull_i), .rd_en(rd[1]), .ld_m(ld[1]),
        .ch_sel(ch_b), .xi(xi_b), .wr_en(wr[1]), .fifo_bypass(fb[1]), .clear(cl[1]),
        .busy(bz[1]), .stop_empty(se[1]), .stop_afull(sa[1]), .done(dn[1]));

    intpol2_dn_ctrl #(.CONFIG_WIDTH(CW), .LOG2_D(1), .NCH(2)) u_c (
        .clk(clk), .rstn(rstn), .start(st[2]), .bypass(bypass), .ilen(ilen),
        .empty_i(empty_i), .afull_i(afull_i), .rd_en(rd[2]), .ld_m(ld[2]),
        .ch_sel(ch_c), .xi(xi_c), .wr_en(wr[2]), .fifo_bypass(fb[2]), .clear(cl[2]),
        .busy(bz[2]), .stop_empty(se[2]), .stop_afull(sa[2]), .done(dn[2]));

    typedef struct {
        int   s;
        logic byp;
        int   len;
        int   nch;
        int   d;
        int   erd;
        int   ewr;
    } vec_t;

    vec_t       tbl [8];
    logic [1:0] sel      = 2'd0;
    logic       cur_byp  = 1'b0;
    logic       mon_sb   = 1'b1;
    logic       rnd_mode = 1'b0;
    logic       man_empty = 1'b0;
    logic       man_afull = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         cnt_rd, cnt_wr, cnt_done, cnt_clr, ovl_cnt;
    int         exp_w[$];
    int         exp_r[$];

    logic m_rd, m_ld, m_wr, m_fb, m_cl, m_bz, m_se, m_sa, m_dn;
    int   m_ch, m_xi;

    assign m_rd = rd[sel];
    assign m_ld = ld[sel];
    assign m_wr = wr[sel];
    assign m_fb = fb[sel];
    assign m_cl = cl[sel];
    assign m_bz = bz[sel];
    assign m_se = se[sel];
    assign m_sa = sa[sel];
    assign m_dn = dn[sel];

    always_comb begin
        m_ch = 0;
        m_xi = 0;
        case (sel)
            2'd0:    begin m_ch = int'(ch_a); m_xi = int'(xi_a); end
            2'd1:    begin m_ch = int'(ch_b); m_xi = int'(xi_b); end
            default: begin m_ch = int'(ch_c); m_xi = int'(xi_c); end
        endcase
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        empty_i = 1'b0;
        afull_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                empty_i = ($urandom_range(0, 2) == 0);
                afull_i = ($urandom_range(0, 2) == 0);
            end else begin
                empty_i = man_empty;
                afull_i = man_afull;
            end
        end
    end

    // per-cycle flag tracking and write/load scoreboard
    always @(negedge clk) begin
        int e;
        if (rstn) begin
            if (m_rd) cnt_rd = cnt_rd + 1;
            if (m_wr) cnt_wr = cnt_wr + 1;
            if (m_dn) cnt_done = cnt_done + 1;
            if (m_cl) cnt_clr = cnt_clr + 1;
            if (m_fb && empty_i && afull_i) ovl_cnt = ovl_cnt + 1;
            if (!m_bz) begin
                chk("idle_quiet", int'({m_rd, m_wr, m_ld, m_se, m_sa}), 0);
            end else if (!m_dn) begin
                chk("fifo_bypass", int'(m_fb), int'(cur_byp));
                if (cur_byp) begin
                    chk("byp_rd_eq_wr", int'(m_rd), int'(m_wr));
                    chk("byp_ld", int'(m_ld), 0);
                    if (empty_i) begin
                        chk("byp_stop_empty", int'(m_se), 1);
                        chk("byp_stop_afull", int'(m_sa), 0);
                        chk("byp_no_xfer", int'(m_rd), 0);
                    end else begin
                        chk("byp_stop_afull", int'(m_sa), int'(afull_i));
                        chk("byp_xfer", int'(m_rd), int'(!afull_i));
                    end
                end else begin
                    chk("phase", int'(m_rd | m_se) + int'(m_wr | m_sa), 1);
                    if (m_rd | m_se) begin
                        chk("stop_empty", int'(m_se), int'(empty_i));
                        chk("ld_eq_rd", int'(m_ld), int'(m_rd));
                    end
                    if (m_wr | m_sa)
                        chk("stop_afull", int'(m_sa), int'(afull_i));
                end
            end
            if (mon_sb && m_wr) begin
                if (exp_w.size() == 0) begin
                    chk("wr_extra", 1, 0);
                end else begin
                    e = exp_w.pop_front();
                    chk("wr_ch_xi", m_ch * 16 + m_xi, e);
                end
            end
            if (mon_sb && m_ld) begin
                if (exp_r.size() == 0) begin
                    chk("ld_extra", 1, 0);
                end else begin
                    e = exp_r.pop_front();
                    chk("ld_ch", m_ch, e);
                end
            end
        end
    end

    task automatic run_vec(input int s, input logic byp, input int len, input int nch,
                           input int d, input int erd, input int ewr, input string nm);
        int lat;
        bit seen;
        exp_w.delete();
        exp_r.delete();
        if (byp) begin
            for (int k = 0; k < len; k++)
                for (int c = 0; c < nch; c++)
                    exp_w.push_back(c * 16);
        end else if (len >= 3) begin
            for (int p = 0; p < 2; p++)
                for (int c = 0; c < nch; c++)
                    exp_r.push_back(c);
            for (int k = 0; k < len - 2; k++)
                for (int c = 0; c < nch; c++) begin
                    exp_r.push_back(c);
                    for (int x = 0; x < d; x++)
                        exp_w.push_back(c * 16 + x);
                end
        end
        @(posedge clk);
        #1;
        sel      = 2'(s);
        cur_byp  = byp;
        bypass   = byp;
        ilen     = CW'(len);
        cnt_rd   = 0;
        cnt_wr   = 0;
        cnt_done = 0;
        cnt_clr  = 0;
        st[s]    = 1'b1;
        @(posedge clk);
        #1;
        st[s]  = 1'b0;
        bypass = ~byp;
        ilen   = '1;
        seen = 0;
        lat  = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            lat = lat + 1;
            if (m_dn) seen = 1;
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        if (erd == 0 && ewr == 0)
            chk({nm, "_done_lat_le2"}, int'(lat <= 2), 1);
        @(negedge clk);
        chk({nm, "_busy_after_done"}, int'(m_bz), 0);
        chk({nm, "_reads"}, cnt_rd, erd);
        chk({nm, "_writes"}, cnt_wr, ewr);
        chk({nm, "_done_pulses"}, cnt_done, 1);
        chk({nm, "_clear_pulses"}, cnt_clr, 1);
        chk({nm, "_wr_left"}, exp_w.size(), 0);
        chk({nm, "_ld_left"}, exp_r.size(), 0);
    endtask

    initial begin
        bit seen;
        st     = 3'b000;
        bypass = 1'b0;
        ilen   = '0;
        rstn   = 1'b0;
        tbl[0] = '{0, 1'b0, 5, 1, 4, 5, 12};
        tbl[1] = '{1, 1'b0, 4, 3, 2, 12, 12};
        tbl[2] = '{0, 1'b0, 2, 1, 4, 0, 0};
        tbl[3] = '{1, 1'b0, 0, 3, 2, 0, 0};
        tbl[4] = '{2, 1'b1, 0, 2, 2, 0, 0};
        tbl[5] = '{2, 1'b1, 3, 2, 2, 6, 6};
        tbl[6] = '{1, 1'b1, 1, 3, 2, 3, 3};
        tbl[7] = '{0, 1'b0, 3, 1, 4, 3, 4};

        repeat (3) @(negedge clk);
        chk("reset_a", int'({rd[0], ld[0], wr[0], fb[0], cl[0], bz[0], se[0], sa[0], dn[0], ch_a, xi_a}), 0);
        chk("reset_b", int'({rd[1], ld[1], wr[1], fb[1], cl[1], bz[1], se[1], sa[1], dn[1], ch_b, xi_b}), 0);
        chk("reset_c", int'({rd[2], ld[2], wr[2], fb[2], cl[2], bz[2], se[2], sa[2], dn[2], ch_c, xi_c}), 0);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i].s, tbl[i].byp, tbl[i].len, tbl[i].nch, tbl[i].d,
                    tbl[i].erd, tbl[i].ewr, $sformatf("v%0d", i));

        // random FIFO stalls plus a stray start while busy
        rnd_mode = 1'b1;
        fork
            run_vec(1, 1'b0, 4, 3, 2, 12, 12, "stall");
            begin
                repeat (10) @(posedge clk);
                #1 st[1] = 1'b1;
                @(posedge clk);
                #1 st[1] = 1'b0;
            end
        join
        rnd_mode = 1'b0;

        // bypass with empty_i and afull_i both high for two cycles
        ovl_cnt = 0;
        fork
            run_vec(2, 1'b1, 3, 2, 2, 6, 6, "byp_ovl");
            begin
                repeat (4) @(negedge clk);
                man_empty = 1'b1;
                man_afull = 1'b1;
                repeat (2) @(negedge clk);
                man_empty = 1'b0;
                man_afull = 1'b0;
            end
        join
        chk("byp_ovl_cycles", ovl_cnt, 2);

        // reset asserted mid-CALC
        mon_sb  = 1'b0;
        sel     = 2'd0;
        cur_byp = 1'b0;
        @(posedge clk);
        #1;
        bypass = 1'b0;
        ilen   = CW'(5);
        st[0]  = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (wr[0]) seen = 1;
        end
        chk("rst_reached_calc", int'(seen), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_outputs", int'({rd[0], ld[0], wr[0], fb[0], cl[0], bz[0], se[0], sa[0], dn[0], ch_a, xi_a}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", int'({dn[0], bz[0]}), 0);
        end
        rstn   = 1'b1;
        mon_sb = 1'b1;
        run_vec(0, 1'b0, 5, 1, 4, 5, 12, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
